reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank.sv | 77 +++++++
 tb/tb_reg_bank.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// 32-entry register file: two combinational read ports, one write port, r0 hardwired to zero.
// Latency: reads are zero-cycle; a write commits on the rising edge and is bypassed to matching reads before it.
// Backpressure: none; one write is accepted every cycle that reg_write is high.
module reg_bank #(
    parameter int unsigned          DATA_W  = 32,
    parameter logic [DATA_W-1:0]    SP_INIT = DATA_W'(227)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reg_write,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int unsigned NUM_REGS = 32;
    localparam logic [4:0]  SP_IDX   = 5'd29;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // A write that will actually land this edge: not in reset, enabled, and not aimed at r0.
    logic wr_commit;
    logic byp1_hit;
    logic byp2_hit;

    assign wr_commit = reset_n && reg_write && (write_reg != 5'd0);
    assign byp1_hit  = wr_commit && (read_reg1 == write_reg);
    assign byp2_hit  = wr_commit && (read_reg2 == write_reg);

    // Next-state for the array: reset image dominates any write; r0 is never stored as non-zero.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
            end
            regs_d[SP_IDX] = SP_INIT;
        end else if (wr_commit) begin
            regs_d[write_reg] = write_data;
        end
        regs_d[0] = '0;
    end

    // State register; reset is folded into regs_d so it is sampled synchronously here.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    // Read port 1: r0 forced to zero (covers the undefined pre-reset storage), then bypass, then array.
    always_comb begin
        read_data1 = regs_q[read_reg1];
        if (read_reg1 == 5'd0) begin
            read_data1 = '0;
        end else if (byp1_hit) begin
            read_data1 = write_data;
        end
    end

    // Read port 2: same selection as port 1, independent bypass decision.
    always_comb begin
        read_data2 = regs_q[read_reg2];
        if (read_reg2 == 5'd0) begin
            read_data2 = '0;
        end else if (byp2_hit) begin
            read_data2 = write_data;
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Randomized and directed bench for reg_bank against an array-based reference model.
// Inputs change 1ns after the rising edge; outputs are compared mid-cycle, before the next edge.
// The DUT has no flow control, so every cycle presents a fresh stimulus vector.
module tb_reg_bank;

    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] SP_VAL = 32'd227;

    logic              clk;
    logic              reset_n;
    logic              reg_write;
    logic [4:0]        write_reg;
    logic [DATA_W-1:0] write_data;
    logic [4:0]        read_reg1;
    logic [4:0]        read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;

    int vectors;
    int miscompares;

    // Reference contents: what each architectural register holds after the last edge.
    logic [DATA_W-1:0] model [32];

    reg_bank #(.DATA_W(DATA_W), .SP_INIT(SP_VAL)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What a read of idx must return right now, from the architectural rules.
    function automatic logic [DATA_W-1:0] expect_read(input logic [4:0] idx);
        if (idx == 5'd0)
            return '0;
        if (reset_n && reg_write && write_reg != 5'd0 && idx == write_reg)
            return write_data;
        return model[idx];
    endfunction

    // Apply the effect of the current inputs to the model, then advance one edge.
    task automatic tick();
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
            model[29] = SP_VAL;
        end else if (reg_write && write_reg != 5'd0) begin
            model[write_reg] = write_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset_n    = 1'b1;
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0;
        read_reg1 = '0; read_reg2 = '0;
        tick();
        idle_inputs();
        read_reg1 = 5'd29; read_reg2 = 5'd5;
        #1;
        vectors++;
        if (read_data1 !== 32'd227) begin
            miscompares++;
            $display("FAIL reset_sp: got %h want %h", read_data1, 32'd227);
        end
        vectors++;
        if (read_data2 !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_r5: got %h want 0", read_data2);
        end
        for (int i = 0; i < 32; i++) begin
            logic [DATA_W-1:0] want;
            read_reg1 = 5'(i);
            read_reg2 = 5'(31 - i);
            #1;
            want = (i == 29) ? SP_VAL : '0;
            vectors++;
            if (read_data1 !== want) begin
                miscompares++;
                $display("FAIL reset_sweep_p1 idx %0d: got %h want %h", i, read_data1, want);
            end
            want = (31 - i == 29) ? SP_VAL : '0;
            vectors++;
            if (read_data2 !== want) begin
                miscompares++;
                $display("FAIL reset_sweep_p2 idx %0d: got %h want %h", 31 - i, read_data2, want);
            end
        end
    endtask

    task automatic test_write_read();
        reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hDEADBEEF;
        read_reg1 = 5'd1; read_reg2 = 5'd2;
        #1;
        tick();
        idle_inputs();
        read_reg1 = 5'd8;
        #1;
        vectors++;
        if (read_data1 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL write_r8: got %h want deadbeef", read_data1);
        end
    endtask

    task automatic test_r0();
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
        read_reg1 = 5'd0; read_reg2 = 5'd0;
        #1;
        vectors++;
        if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
            miscompares++;
            $display("FAIL r0_pre: got %h/%h want 0/0", read_data1, read_data2);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
            miscompares++;
            $display("FAIL r0_post: got %h/%h want 0/0", read_data1, read_data2);
        end
    endtask

    task automatic test_bypass();
        reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h00400010;
        read_reg1 = 5'd31; read_reg2 = 5'd31;
        #1;
        vectors++;
        if (read_data1 !== 32'h00400010 || read_data2 !== 32'h00400010) begin
            miscompares++;
            $display("FAIL bypass_pre: got %h/%h want 00400010", read_data1, read_data2);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (read_data1 !== 32'h00400010 || read_data2 !== 32'h00400010) begin
            miscompares++;
            $display("FAIL bypass_post: got %h/%h want 00400010", read_data1, read_data2);
        end
        // Bypass must be suppressed while reset is low: stored r31 shows, not write_data.
        reset_n = 1'b0; reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h55AA55AA;
        #1;
        vectors++;
        if (read_data1 !== 32'h00400010) begin
            miscompares++;
            $display("FAIL bypass_in_reset: got %h want 00400010", read_data1);
        end
        reset_n = 1'b1; reg_write = 1'b0;
        #1;
    endtask

    task automatic test_reset_dominates();
        reg_write = 1'b1; write_reg = 5'd29; write_data = 32'h1234;
        tick();
        write_reg = 5'd3; write_data = 32'd7;
        tick();
        idle_inputs();
        read_reg1 = 5'd29; read_reg2 = 5'd3;
        #1;
        vectors++;
        if (read_data1 !== 32'h1234 || read_data2 !== 32'd7) begin
            miscompares++;
            $display("FAIL pre_reset_vals: got %h/%h want 1234/7", read_data1, read_data2);
        end
        reset_n = 1'b0; reg_write = 1'b1; write_reg = 5'd3; write_data = 32'd9;
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (read_data1 !== 32'd227 || read_data2 !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_dominates: got %h/%h want e3/0", read_data1, read_data2);
        end
    endtask

    task automatic test_back_to_back();
        reg_write = 1'b1; write_reg = 5'd10; write_data = 32'd1;
        read_reg1 = 5'd0; read_reg2 = 5'd10;
        #1;
        vectors++;
        if (read_data2 !== 32'd1) begin
            miscompares++;
            $display("FAIL b2b_first: got %h want 1", read_data2);
        end
        tick();
        write_data = 32'd2;
        #1;
        vectors++;
        if (read_data2 !== 32'd2) begin
            miscompares++;
            $display("FAIL b2b_second: got %h want 2", read_data2);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (read_data2 !== 32'd2) begin
            miscompares++;
            $display("FAIL b2b_final: got %h want 2", read_data2);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [DATA_W-1:0] e1;
            logic [DATA_W-1:0] e2;
            reset_n    = ($urandom_range(0, 29) != 0);
            reg_write  = $urandom_range(0, 1) == 1;
            write_reg  = 5'($urandom_range(0, 31));
            write_data = $urandom;
            // Bias reads toward the write index so bypass paths are hit often.
            read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            read_reg2  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            #1;
            e1 = expect_read(read_reg1);
            e2 = expect_read(read_reg2);
            vectors++;
            if (read_data1 !== e1) begin
                miscompares++;
                $display("FAIL rand_p1 cyc %0d idx %0d: got %h want %h", n, read_reg1, read_data1, e1);
            end
            vectors++;
            if (read_data2 !== e2) begin
                miscompares++;
                $display("FAIL rand_p2 cyc %0d idx %0d: got %h want %h", n, read_reg2, read_data2, e2);
            end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 32; i++) begin
            logic [DATA_W-1:0] want;
            read_reg1 = 5'(i);
            read_reg2 = 5'(i);
            #1;
            want = (i == 0) ? '0 : model[i];
            vectors++;
            if (read_data1 !== want || read_data2 !== want) begin
                miscompares++;
                $display("FAIL rand_sweep idx %0d: got %h/%h want %h", i, read_data1, read_data2, want);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_write_read();
        test_r0();
        test_bypass();
        test_reset_dominates();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
